demux2_stream: RTL
==================

DEMUX2_STREAM -- requirements
Module: demux2_stream

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, the data width in bits.
REQ-002 The block SHALL have a single clock; reset is synchronous and active-low.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 in_valid  input  1  upstream word present.
REQ-006 in_ready  output  1  block accepts the word this cycle.
REQ-007 in_data  input  WIDTH  upstream word.
REQ-008 in_sel  input  1  destination of the word: 0 routes to out0, 1 routes to out1.
REQ-009 out0_valid / out1_valid  output  1  output slot holds a word.
REQ-010 out0_ready / out1_ready  input  1  downstream accepts the word.
REQ-011 out0_data / out1_data  output  WIDTH  output word.
REQ-012 cnt0 / cnt1  output  8  transfer counts per output; present only with DEMUX2_CNT_EN.

Function
REQ-013 Each output SHALL have a one-entry slot with two states, EMPTY (outN_valid=0) and FULL (outN_valid=1).
REQ-014 An input transfer SHALL occur on a cycle with in_valid=1 and in_ready=1; an output transfer SHALL occur on a cycle with outN_valid=1 and outN_ready=1.
REQ-015 in_ready SHALL be combinational: in_ready = !outS_valid || outS_ready, where S=in_sel. It SHALL NOT depend on in_valid.
REQ-016 On an input transfer, in_data SHALL be loaded into slot S, and outS_valid SHALL be 1 from the next cycle (latency 1).
REQ-017 Slot transitions: EMPTY->FULL on load; FULL->EMPTY on output transfer with no load; FULL->FULL with new data when output transfer and load occur in the same cycle.
REQ-018 While FULL and not transferred, outN_data and outN_valid SHALL hold stable regardless of the input signals.
REQ-019 The two slots SHALL be independent. A stalled out1 (FULL, out1_ready=0) SHALL NOT block words with in_sel=0, and the reverse also holds.
REQ-020 Words SHALL leave each output in the order they were accepted for that output; no word SHALL be dropped or duplicated.
REQ-021 If in_valid=0, or in_ready=0 for the selected slot, neither slot SHALL be loaded; in_data and in_sel are don't-care.
REQ-022 With both slots EMPTY and in_valid held at 1, the block SHALL sustain one transfer per cycle when the destination is ready every cycle.

Reset
REQ-023 While rst_n=0 at a rising edge, out0_valid and out1_valid SHALL be 0 and out0_data and out1_data SHALL be 0 at the next cycle; cnt0 and cnt1 SHALL also be 0 when present.
REQ-024 In-flight slot contents SHALL be discarded on reset, with no output transfer reported.
REQ-025 in_ready SHALL follow REQ-015 during reset (1 once slots are EMPTY); any word presented during a reset cycle SHALL be ignored.

Configuration
REQ-026 Macro DEMUX2_CNT_EN: when defined, cnt0 and cnt1 SHALL exist and increment by 1 on each output transfer of their output, saturating at 255.
REQ-027 When DEMUX2_CNT_EN is not defined, the ports cnt0 and cnt1 and their registers SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-028 Reset with in_valid=1 and in_data=8'hA5 -> out0_valid=0, out1_valid=0, out data 0, counters 0; the word is not delivered.
REQ-029 Single word 8'h3C with sel=0 and out0_ready=1 -> out0_valid=1 with data 8'h3C one cycle later, for exactly one cycle; out1_valid stays 0.
REQ-030 out1_ready=0; send 8'h11 with sel=1, then 8'h22 with sel=1 -> in_ready=0 while sel=1; a word 8'h33 with sel=0 is still accepted and appears on out0.
REQ-031 Slot 0 FULL with 8'h44, out0_ready=1, and 8'h55 with sel=0 in the same cycle -> in_ready=1; out0 shows 8'h44 then 8'h55 on consecutive cycles with valid continuously 1.
REQ-032 Back-to-back stream alternating sel=0,1 for 10 cycles with both readies=1 -> 10 transfers in 10 cycles, order preserved per output, cnt0=5 and cnt1=5 (DEMUX2_CNT_EN defined).
REQ-033 300 transfers to out0 with DEMUX2_CNT_EN defined -> cnt0 saturates at 255; reset mid-stream with slot 1 FULL -> out1_valid=0 next cycle.

Source files
------------

// File: rtl/demux2_stream.sv
// One-to-two stream demultiplexer: in_sel steers each word into a one-entry slot per output.
// Optional DEMUX2_CNT_EN adds saturating 8-bit transfer counters cnt0/cnt1.
module demux2_stream #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data
`ifdef DEMUX2_CNT_EN
  ,
  output logic [7:0]       cnt0,
  output logic [7:0]       cnt1
`endif
);

  localparam int unsigned NUM_OUT = 2;
  localparam int unsigned CNT_W   = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

  slot_state_t            state_q [NUM_OUT];
  logic [WIDTH-1:0]       data_q  [NUM_OUT];
  logic [NUM_OUT-1:0]     valid;
  logic [NUM_OUT-1:0]     ready;
  logic [NUM_OUT-1:0]     load;
  logic [NUM_OUT-1:0]     take;

  assign valid[0] = (state_q[0] == FULL);
  assign valid[1] = (state_q[1] == FULL);
  assign ready    = {out1_ready, out0_ready};

  // A slot can accept when empty or when its current word leaves this cycle.
  assign in_ready = in_sel ? (!valid[1] || ready[1]) : (!valid[0] || ready[0]);

  assign load[0] = in_valid && in_ready && !in_sel;
  assign load[1] = in_valid && in_ready &&  in_sel;
  assign take    = valid & ready;

  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(NUM_OUT); i++) begin
      if (!rst_n) begin
        state_q[i] <= EMPTY;
        data_q[i]  <= '0;
      end else begin
        case (state_q[i])
          EMPTY: begin
            if (load[i]) begin
              state_q[i] <= FULL;
              data_q[i]  <= in_data;
            end
          end
          FULL: begin
            if (load[i]) begin
              data_q[i] <= in_data;
            end else if (take[i]) begin
              state_q[i] <= EMPTY;
            end
          end
          default: state_q[i] <= EMPTY;
        endcase
      end
    end
  end

  assign out0_valid = valid[0];
  assign out1_valid = valid[1];
  assign out0_data  = data_q[0];
  assign out1_data  = data_q[1];

`ifdef DEMUX2_CNT_EN
  logic [CNT_W-1:0] cnt_q [NUM_OUT];

  // Count output transfers, sticking at all-ones.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(NUM_OUT); i++) begin
      if (!rst_n) begin
        cnt_q[i] <= '0;
      end else if (take[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
        cnt_q[i] <= cnt_q[i] + CNT_W'(1);
      end
    end
  end

  assign cnt0 = cnt_q[0];
  assign cnt1 = cnt_q[1];
`endif

endmodule
